// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: registered N:1 operand select behind a valid/ready handshake.
// Define PIPE_SEL_MUX_SKID_EN for the two-entry skid build (no comb ready path).
module pipe_sel_mux #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 6,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("pipe_sel_mux: NUM_IN must be in 2..16");
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] cap_data;
    logic             sel_ok;
    logic             in_xfer;

    // Out-of-range selects capture zero rather than an undefined slice.
    always_comb begin
        cap_data = '0;
        sel_ok   = (32'(in_sel) < NUM_IN);
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(in_sel) == k) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PIPE_SEL_MUX_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q | (in_xfer && !sel_ok);
        if ((!out_valid_q || out_ready) && !skid_valid_q) begin
            if (in_xfer) begin
                out_data_d  = cap_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready && skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (in_xfer) begin
            skid_data_d  = cap_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q | (in_xfer && !sel_ok);
        if (in_xfer) begin
            out_data_d  = cap_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule
